// File: rtl/md_seq_ctrl_pkg.sv
// Shared encodings, state enum and helpers for the multiply/divide sequencer.
package md_pkg;
   localparam int MD_STEPS = 32;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   localparam logic [31:0] MD_DIV0_QUO = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} md_state_e;

   // Magnitude of a 32-bit operand; 0x80000000 maps onto itself, which the unsigned core handles.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (~v + 32'd1) : v;
   endfunction
endpackage

// File: rtl/md_seq_ctrl_if.sv
// Request/result bundle between the EX stage and the mul/div sequencer.
interface md_seq_ctrl_if;
   logic        req_valid;
   logic [1:0]  req_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        annul;
   logic        busy;
   logic        stallreq;
   logic        res_valid;
   logic [31:0] res_hi;
   logic [31:0] res_lo;

   modport master (
      output req_valid, req_op, src_a, src_b, annul,
      input  busy, stallreq, res_valid, res_hi, res_lo
   );

   modport slave (
      input  req_valid, req_op, src_a, src_b, annul,
      output busy, stallreq, res_valid, res_hi, res_lo
   );
endinterface

// File: rtl/md_seq_ctrl_core.sv
// Shared 64-bit accumulator: unsigned shift-add multiply or restoring divide, one step per cycle.
// raw_res is the accumulator value after the current step, so the last step can be captured directly.
module md_iter_core (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   input  logic        is_div,
   input  logic [31:0] a_mag,
   input  logic [31:0] b_mag,
   output logic [63:0] raw_res
);
   logic [63:0] acc;
   logic [31:0] opnd;
   logic        div_mode;
   logic [32:0] sum;
   logic [32:0] trial;

   // Multiply: {hi,lo} with multiplier in lo. Divide: {rem,quo} with dividend in quo.
   always_comb begin
      sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
      trial = acc[63:31] - {1'b0, opnd};
      if (div_mode)
         raw_res = trial[32] ? {acc[62:0], 1'b0} : {trial[31:0], acc[30:0], 1'b1};
      else
         raw_res = {sum, acc[31:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         opnd     <= '0;
         div_mode <= 1'b0;
      end else if (load) begin
         acc      <= {32'd0, is_div ? a_mag : b_mag};
         opnd     <= is_div ? b_mag : a_mag;
         div_mode <= is_div;
      end else if (step) begin
         acc      <= raw_res;
      end
   end
endmodule

// File: rtl/md_seq_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: 33-cycle accept-to-result (1 cycle for divide by zero),
// stalls the pipeline while working; annul abandons the operation without touching the result registers.
module md_seq_ctrl
   import md_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   md_seq_ctrl_if.slave    bus
);
   localparam int CNT_W = $clog2(MD_STEPS);

   md_state_e         state, state_n;
   logic [CNT_W-1:0]  cnt;
   logic              is_div_q, qneg_q, rneg_q;
   logic              load, step, accept, last;
   logic              op_is_mul, op_is_div, op_signed, div0;
   logic [31:0]       a_mag, b_mag;
   logic [63:0]       raw_res, fix;

   assign op_is_mul = (bus.req_op == MD_MULT) || (bus.req_op == MD_MULTU);
   assign op_is_div = (bus.req_op == MD_DIV)  || (bus.req_op == MD_DIVU);
   assign op_signed = (bus.req_op == MD_MULT) || (bus.req_op == MD_DIV);
   assign div0      = op_is_div && (bus.src_b == 32'd0);
   assign a_mag     = mag32(bus.src_a, op_signed);
   assign b_mag     = mag32(bus.src_b, op_signed);
   assign accept    = (state == IDLE) && bus.req_valid && !bus.annul;
   assign last      = (cnt == CNT_W'(MD_STEPS - 1));

   always_comb begin
      state_n = state;
      load    = 1'b0;
      step    = 1'b0;
      case (state)
         IDLE: if (accept) begin
            if (div0) begin
               state_n = DONE;
            end else begin
               load    = 1'b1;
               state_n = op_is_mul ? MUL : DIV;
            end
         end
         MUL, DIV: begin
            step = 1'b1;
            if (last) state_n = DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (bus.annul) begin
         state_n = IDLE;
         load    = 1'b0;
         step    = 1'b0;
      end
   end

   // Remainder follows the dividend's sign; quotient/product negate when operand signs differ.
   always_comb begin
      if (is_div_q)
         fix = {rneg_q ? -raw_res[63:32] : raw_res[63:32],
                qneg_q ? -raw_res[31:0]  : raw_res[31:0]};
      else
         fix = qneg_q ? -raw_res : raw_res;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         is_div_q   <= 1'b0;
         qneg_q     <= 1'b0;
         rneg_q     <= 1'b0;
         bus.res_hi <= '0;
         bus.res_lo <= '0;
      end else begin
         state <= state_n;
         if (load) begin
            cnt      <= '0;
            is_div_q <= op_is_div;
            qneg_q   <= op_signed && (bus.src_a[31] ^ bus.src_b[31]);
            rneg_q   <= op_signed && bus.src_a[31];
         end else if (step) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (accept && div0) begin
            bus.res_hi <= bus.src_a;
            bus.res_lo <= MD_DIV0_QUO;
         end else if (step && last) begin
            bus.res_hi <= fix[63:32];
            bus.res_lo <= fix[31:0];
         end
      end
   end

   md_iter_core u_core (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .step    (step),
      .is_div  (op_is_div),
      .a_mag   (a_mag),
      .b_mag   (b_mag),
      .raw_res (raw_res)
   );

   assign bus.busy      = (state != IDLE);
   assign bus.res_valid = (state == DONE) && !bus.annul;
   assign bus.stallreq  = bus.req_valid && !bus.res_valid && !bus.annul && !rst;
endmodule

// File: tb/tb_md_seq_ctrl.sv
// Bench for md_seq_ctrl: vector table run back-to-back through a scoreboard, plus annul and reset sequences.
module tb_md_seq_ctrl;
   import md_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   md_seq_ctrl_if bus();

   md_seq_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   int          total = 0;
   int          bad   = 0;
   exp_t        sb[$];
   vec_t        vecs[13];
   logic [31:0] last_hi, last_lo;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Drive one request (just after a rising edge, DUT in IDLE) and follow it to res_valid.
   task automatic issue(input vec_t v);
      int   n;
      bit   seen;
      exp_t e;
      bus.req_valid = 1'b1;
      bus.req_op    = v.op;
      bus.src_a     = v.a;
      bus.src_b     = v.b;
      e.hi = v.hi;
      e.lo = v.lo;
      sb.push_back(e);
      #1 chk("stall_accept", bus.stallreq, 1);
      n    = 0;
      seen = 0;
      while (!seen && n < 60) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (bus.res_valid) seen = 1;
         else chk("stall_working", bus.stallreq, 1);
      end
      chk("res_seen", seen, 1);
      chk("latency", n, v.lat);
      if (sb.size() > 0) e = sb.pop_front();
      if (seen) begin
         chk("stall_done", bus.stallreq, 0);
         chk("busy_done", bus.busy, 1);
         chk("res_hi", bus.res_hi, e.hi);
         chk("res_lo", bus.res_lo, e.lo);
         last_hi = e.hi;
         last_lo = e.lo;
      end
      @(posedge clk);
      #1;
      chk("idle_after_done", bus.busy, 0);
      chk("single_pulse", bus.res_valid, 0);
      bus.req_valid = 1'b0;
   endtask

   initial begin
      vec_t v;
      vecs[0]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
      vecs[1]  = '{MD_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 33};
      vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
      vecs[3]  = '{MD_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1};
      vecs[4]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
      vecs[5]  = '{MD_DIVU,  32'd10,        32'd3,         32'd1,         32'd3,         33};
      vecs[6]  = '{MD_MULT,  32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 33};
      vecs[7]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33};
      vecs[8]  = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
      vecs[9]  = '{MD_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 33};
      vecs[10] = '{MD_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1};
      vecs[11] = '{MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         33};
      vecs[12] = '{MD_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2,         33};

      bus.req_valid = 1'b0;
      bus.req_op    = 2'b00;
      bus.src_a     = '0;
      bus.src_b     = '0;
      bus.annul     = 1'b0;
      rst           = 1'b1;
      last_hi       = '0;
      last_lo       = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_valid", bus.res_valid, 0);
      chk("rst_hi", bus.res_hi, 0);
      chk("rst_lo", bus.res_lo, 0);
      bus.req_valid = 1'b1;
      #1 chk("rst_stall", bus.stallreq, 0);
      bus.req_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Each request follows the previous one with no gap, so every entry after the first is back-to-back.
      for (int i = 0; i < 13; i++) issue(vecs[i]);

      bus.req_valid = 1'b1;
      bus.req_op    = MD_MULT;
      bus.src_a     = 32'd9;
      bus.src_b     = 32'd11;
      repeat (10) begin
         @(posedge clk);
         #1 chk("annul_pre_valid", bus.res_valid, 0);
      end
      bus.annul = 1'b1;
      #1 chk("annul_stall", bus.stallreq, 0);
      @(posedge clk);
      #1;
      bus.annul = 1'b0;
      chk("annul_busy", bus.busy, 0);
      chk("annul_valid", bus.res_valid, 0);
      chk("annul_hi_kept", bus.res_hi, last_hi);
      chk("annul_lo_kept", bus.res_lo, last_lo);
      v = '{MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 33};
      issue(v);

      bus.req_valid = 1'b1;
      bus.req_op    = MD_DIV;
      bus.src_a     = 32'd1000;
      bus.src_b     = 32'd7;
      repeat (20) begin
         @(posedge clk);
         #1 chk("rst_pre_valid", bus.res_valid, 0);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_valid", bus.res_valid, 0);
      chk("midrst_hi", bus.res_hi, 0);
      chk("midrst_lo", bus.res_lo, 0);
      chk("midrst_stall", bus.stallreq, 0);
      rst = 1'b0;
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("postrst_busy", bus.busy, 0);
      chk("postrst_valid", bus.res_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/md_seq_ctrl.md
# md_seq_ctrl

Multi-cycle multiply/divide sequencer for the EX stage. It accepts one MULT/MULTU/DIV/DIVU request, runs a 32-step shift-add (multiply) or restoring shift-subtract (divide) iteration on a shared datapath, and asserts a stall request until the 64-bit HI/LO result is delivered. It replaces the separate multiplier and divider plus their inline start/ready glue with a single sequenced resource.

## Interface
- MD_STEPS, 32, number of iteration cycles; operand width is fixed at 32.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  a mul/div instruction is present in EX; held high until `res_valid` is seen.
- req_op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- src_a  in  32  multiplicand or dividend (rs).
- src_b  in  32  multiplier or divisor (rt).
- annul  in  1  flush; abandons any operation in progress.
- busy  out  1  state is not IDLE.
- stallreq  out  1  stall request to the pipeline control unit.
- res_valid  out  1  single-cycle pulse; `res_hi`/`res_lo` are valid in that cycle.
- res_hi  out  32  product[63:32], or remainder.
- res_lo  out  32  product[31:0], or quotient.

## Operation
- States are IDLE, MUL, DIV and DONE.
- **IDLE**: if `req_valid & ~annul`:
  - Latch the op, the operand magnitudes (absolute value when signed), and the result sign flags.
  - Clear the step counter.
  - Go to MUL for ops 00/01, DIV for ops 10/11.
- **Divide by zero** (`src_b==0`, op 1x): IDLE goes straight to DONE with `res_hi=src_a` and `res_lo=32'hFFFF_FFFF`. No sign fixup is applied.
- **MUL**: one shift-add step per cycle on a 64-bit accumulator.
- **DIV**: one restoring step per cycle: shift {rem,quo} left by 1, trial-subtract the divisor, set the quotient bit if the result is ≥0.
- **Leaving MUL/DIV**: when the counter reaches MD_STEPS-1, go to DONE. On that edge, register the sign-fixed result into `res_hi`/`res_lo`.
- **Sign rules**:
  - mult: negate the 64-bit product when sign(a)≠sign(b).
  - div: negate the quotient when the signs differ; the remainder takes the sign of the dividend.
  - 0x80000000 / -1 yields quotient 0x80000000, remainder 0 (wraps, no trap).
- **DONE**: `res_valid=1`, then go to IDLE unconditionally. A new request can only be accepted in IDLE.
- **Request handling**: `req_valid` and operands are ignored outside IDLE; the latched copies are used.
- **annul**: from any state, go to IDLE on the next edge.
  - `res_valid` is not produced.
  - `res_hi`/`res_lo` keep their previous values.
  - annul has priority over acceptance.
- **rst**: overrides everything. State goes to IDLE; counter, accumulators, `res_hi` and `res_lo` go to 0.
- **stallreq** = `req_valid & ~res_valid & ~annul & ~rst`.
  - It is high in the accept cycle and throughout MUL/DIV.
  - It is low in the DONE cycle so that EX advances with the result.
- **Outputs**:
  - `busy` is registered-state decoded.
  - `res_valid` = (state==DONE).
  - `res_hi`/`res_lo` are registered.

## Timing
- Request sampled at edge 0; iteration edges 1..MD_STEPS; DONE is the cycle after edge MD_STEPS.
- Accept-to-`res_valid` latency is 33 cycles for mul and nonzero div, 1 cycle for div-by-zero.
- `stallreq` is combinational from `req_valid`, `annul` and the state. There is no register in that path.
- Back-to-back requests: a second op is accepted in the IDLE cycle following DONE, at the earliest one cycle after `res_valid`.
- `annul` asserted in the same cycle as DONE suppresses `res_valid`, and `res_hi`/`res_lo` keep their prior values.
- Reset asserted mid-operation: the next cycle is IDLE with all outputs 0.

## Structure
- Shared package `md_pkg` holds:
  - the op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - the state enum {IDLE, MUL, DIV, DONE};
  - MD_STEPS;
  - the divide-by-zero quotient constant 32'hFFFF_FFFF.
- One sub-module, `md_iter_core`, holds the 64-bit accumulator and the add/subtract step logic.
  - Inputs: `load`, `step`, `is_div`, the operand magnitudes.
  - Outputs: the raw 64-bit result.
- `md_seq_ctrl` owns the FSM, the counter, the sign handling, the output registers and `stallreq`.

## Test plan
- multu FFFFFFFF×FFFFFFFF → `res_valid` 33 cycles after accept; hi=FFFFFFFE, lo=00000001; `stallreq` high for 33 cycles, then low.
- mult -3×5 → hi=FFFFFFFF, lo=FFFFFFF1; signed div -7/2 → lo=FFFFFFFD, hi=FFFFFFFF.
- divu 100/0 → `res_valid` 1 cycle after accept; hi=00000064, lo=FFFFFFFF.
- div 80000000/FFFFFFFF → lo=80000000, hi=0; then an immediate second request (divu 10/3) is accepted the cycle after DONE → lo=3, hi=1 after 33 more cycles.
- `annul` at cycle 10 of a mult → IDLE next cycle, no `res_valid`, `res_hi`/`res_lo` unchanged; a new request is accepted the following cycle.
- `rst` at cycle 20 of a div → all outputs 0 next cycle, `busy`=0, no `res_valid`.
